// File: rtl/ex_serial_pkg.sv
// ex_serial_pkg: shared opcodes, result classes, bus widths and EX state encodings
package ex_serial_pkg;
  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;
  localparam int AluOpBus   = 8;
  localparam int AluSelBus  = 3;
  localparam logic [RegBus-1:0]     ZeroWord   = '0;
  localparam logic [RegAddrBus-1:0] NOPRegAddr = '0;
  localparam logic RST_ACTIVE = 1'b0;
  localparam logic [AluOpBus-1:0] EXE_NOP_OP = 8'b0000_0000;
  localparam logic [AluOpBus-1:0] EXE_AND_OP = 8'b0010_0100;
  localparam logic [AluOpBus-1:0] EXE_OR_OP  = 8'b0010_0101;
  localparam logic [AluOpBus-1:0] EXE_XOR_OP = 8'b0010_0110;
  localparam logic [AluOpBus-1:0] EXE_NOR_OP = 8'b0010_0111;
  localparam logic [AluOpBus-1:0] EXE_SLL_OP = 8'b0111_1100;
  localparam logic [AluOpBus-1:0] EXE_SRL_OP = 8'b0000_0010;
  localparam logic [AluOpBus-1:0] EXE_SRA_OP = 8'b0000_0011;
  localparam logic [AluSelBus-1:0] EXE_RES_NOP   = 3'b000;
  localparam logic [AluSelBus-1:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [AluSelBus-1:0] EXE_RES_SHIFT = 3'b010;
  typedef enum logic [1:0] {EX_IDLE, EX_SHIFTING, EX_DONE} ex_state_e;
endpackage

// File: rtl/ex_shifter.sv
// ex_shifter: iterative shifter and EX state machine (IDLE/SHIFTING/DONE)
//   clk, rst     clock, async active-low reset
//   cap_i        EX register captures a new bundle this edge
//   shift_i      captured bundle is of the SHIFT class
//   aluop_i      op held in the EX register, selects shift direction
//   amt_i/val_i  shift amount and value, loaded on a shift capture
//   busy_o       shifting in progress (front end must freeze)
//   acc_o        shift accumulator, the result once done
module ex_shifter import ex_serial_pkg::*; #(
  parameter int SHIFT_STEP = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cap_i,
  input  logic                shift_i,
  input  logic [AluOpBus-1:0] aluop_i,
  input  logic [4:0]          amt_i,
  input  logic [RegBus-1:0]   val_i,
  output logic                busy_o,
  output logic [RegBus-1:0]   acc_o
);
  ex_state_e state_q, state_d;
  logic [RegBus-1:0] acc_q, acc_d, shifted;
  logic [4:0] cnt_q, cnt_d;
  logic [5:0] step;
  // the last step may be shorter than SHIFT_STEP
  assign step = ({1'b0, cnt_q} < 6'(SHIFT_STEP)) ? {1'b0, cnt_q} : 6'(SHIFT_STEP);
  assign shifted = (aluop_i == EXE_SRL_OP) ? acc_q >> step :
                   (aluop_i == EXE_SRA_OP) ? 32'($signed(acc_q) >>> step) : acc_q << step;
  assign busy_o = state_q == EX_SHIFTING;
  assign acc_o  = acc_q;
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    if (cap_i) begin
      state_d = (shift_i && amt_i != 5'd0) ? EX_SHIFTING : EX_DONE;
      acc_d   = shift_i ? val_i : acc_q;
      cnt_d   = shift_i ? amt_i : cnt_q;
    end else if (state_q == EX_SHIFTING) begin
      acc_d   = shifted;
      cnt_d   = cnt_q - step[4:0];
      state_d = ({1'b0, cnt_q} == step) ? EX_DONE : EX_SHIFTING;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      state_q <= EX_IDLE;
      acc_q   <= ZeroWord;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: rtl/ex_serial.sv
// ex_serial: execute stage with one-cycle logic unit and iterative shifter
//   clk, rst                 clock, async active-low reset
//   aluop_i..wreg_i          decode bundle
//   stall_i                  mem stall: freezes EX capture and ex/mem
//   stall_o                  freeze request to pc/if/id while shifting
//   ex_wreg_o/wd_o/wdata_o   forwarding taps to decode
//   wreg_o/wd_o/wdata_o      ex/mem register
module ex_serial import ex_serial_pkg::*; #(
  parameter int SHIFT_STEP = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [AluOpBus-1:0]   aluop_i,
  input  logic [AluSelBus-1:0]  alusel_i,
  input  logic [RegBus-1:0]     reg1_i,
  input  logic [RegBus-1:0]     reg2_i,
  input  logic [RegAddrBus-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic                  stall_i,
  output logic                  stall_o,
  output logic                  ex_wreg_o,
  output logic [RegAddrBus-1:0] ex_wd_o,
  output logic [RegBus-1:0]     ex_wdata_o,
  output logic                  wreg_o,
  output logic [RegAddrBus-1:0] wd_o,
  output logic [RegBus-1:0]     wdata_o
);
  logic [AluOpBus-1:0]   aluop_q;
  logic [AluSelBus-1:0]  alusel_q;
  logic [RegBus-1:0]     reg1_q, reg2_q, acc, logic_res;
  logic [RegAddrBus-1:0] wd_q;
  logic                  wreg_q, cap;
  assign cap = ~stall_o & ~stall_i;
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      aluop_q  <= EXE_NOP_OP;
      alusel_q <= EXE_RES_NOP;
      reg1_q   <= ZeroWord;
      reg2_q   <= ZeroWord;
      wd_q     <= NOPRegAddr;
      wreg_q   <= 1'b0;
    end else if (cap) begin
      aluop_q  <= aluop_i;
      alusel_q <= alusel_i;
      reg1_q   <= reg1_i;
      reg2_q   <= reg2_i;
      wd_q     <= wd_i;
      wreg_q   <= wreg_i;
    end
  end
  ex_shifter #(.SHIFT_STEP(SHIFT_STEP)) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .cap_i   (cap),
    .shift_i (alusel_i == EXE_RES_SHIFT),
    .aluop_i (aluop_q),
    .amt_i   (reg1_i[4:0]),
    .val_i   (reg2_i),
    .busy_o  (stall_o),
    .acc_o   (acc)
  );
  assign logic_res = (aluop_q == EXE_AND_OP) ? reg1_q & reg2_q :
                     (aluop_q == EXE_OR_OP)  ? reg1_q | reg2_q :
                     (aluop_q == EXE_XOR_OP) ? reg1_q ^ reg2_q :
                     (aluop_q == EXE_NOR_OP) ? ~(reg1_q | reg2_q) : ZeroWord;
  assign ex_wdata_o = (alusel_q == EXE_RES_LOGIC) ? logic_res :
                      (alusel_q == EXE_RES_SHIFT) ? acc : ZeroWord;
  assign ex_wd_o   = wd_q;
  assign ex_wreg_o = wreg_q & ~stall_o;
  // while shifting, ex/mem receives bubbles unless mem itself is stalled
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      wreg_o  <= 1'b0;
      wd_o    <= NOPRegAddr;
      wdata_o <= ZeroWord;
    end else if (!stall_i) begin
      wreg_o  <= stall_o ? 1'b0 : ex_wreg_o;
      wd_o    <= stall_o ? NOPRegAddr : ex_wd_o;
      wdata_o <= stall_o ? ZeroWord : ex_wdata_o;
    end
  end
endmodule

// File: tb/tb_ex_serial.sv
// tb_ex_serial: directed self-checking bench for ex_serial (SHIFT_STEP 1 and 4)
module tb_ex_serial;
  import ex_serial_pkg::*;
  logic clk = 1'b0, rst = 1'b1, stall_i = 1'b0, wreg = 1'b0;
  logic [7:0] aluop = '0;
  logic [2:0] alusel = '0;
  logic [31:0] reg1 = '0, reg2 = '0;
  logic [4:0] wd = '0;
  logic s1_stall, s1_exwreg, s1_wreg, s4_stall, s4_exwreg, s4_wreg;
  logic [4:0] s1_exwd, s1_wd, s4_exwd, s4_wd;
  logic [31:0] s1_exwdata, s1_wdata, s4_exwdata, s4_wdata;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  ex_serial #(.SHIFT_STEP(1)) dut1 (.clk(clk), .rst(rst), .aluop_i(aluop), .alusel_i(alusel),
    .reg1_i(reg1), .reg2_i(reg2), .wd_i(wd), .wreg_i(wreg), .stall_i(stall_i), .stall_o(s1_stall),
    .ex_wreg_o(s1_exwreg), .ex_wd_o(s1_exwd), .ex_wdata_o(s1_exwdata),
    .wreg_o(s1_wreg), .wd_o(s1_wd), .wdata_o(s1_wdata));
  ex_serial #(.SHIFT_STEP(4)) dut4 (.clk(clk), .rst(rst), .aluop_i(aluop), .alusel_i(alusel),
    .reg1_i(reg1), .reg2_i(reg2), .wd_i(wd), .wreg_i(wreg), .stall_i(stall_i), .stall_o(s4_stall),
    .ex_wreg_o(s4_exwreg), .ex_wd_o(s4_exwd), .ex_wdata_o(s4_exwdata),
    .wreg_o(s4_wreg), .wd_o(s4_wd), .wdata_o(s4_wdata));
  task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] r1, r2,
                       input logic [4:0] d, input logic w);
    @(negedge clk);
    aluop = op; alusel = sel; reg1 = r1; reg2 = r2; wd = d; wreg = w;
  endtask
  task automatic nop();
    drive(EXE_NOP_OP, EXE_RES_NOP, '0, '0, '0, 1'b0);
  endtask
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic test_reset();
    #2 rst = 1'b0;
    tick();
    total += 9;
    if (s1_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", s1_stall); end
    if (s1_exwreg !== 1'b0) begin bad++; $display("FAIL reset_ex_wreg got=%b exp=0", s1_exwreg); end
    if (s1_exwd !== 5'd0) begin bad++; $display("FAIL reset_ex_wd got=%0d exp=0", s1_exwd); end
    if (s1_exwdata !== 32'd0) begin bad++; $display("FAIL reset_ex_wdata got=%h exp=0", s1_exwdata); end
    if (s1_wreg !== 1'b0) begin bad++; $display("FAIL reset_wreg got=%b exp=0", s1_wreg); end
    if (s1_wd !== 5'd0) begin bad++; $display("FAIL reset_wd got=%0d exp=0", s1_wd); end
    if (s1_wdata !== 32'd0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", s1_wdata); end
    if (s4_stall !== 1'b0) begin bad++; $display("FAIL reset_stall4 got=%b exp=0", s4_stall); end
    if (s4_exwdata !== 32'd0) begin bad++; $display("FAIL reset_ex_wdata4 got=%h exp=0", s4_exwdata); end
    @(negedge clk) rst = 1'b1;
  endtask
  task automatic test_logic();
    logic [7:0]  ops [5] = '{EXE_OR_OP, EXE_AND_OP, EXE_XOR_OP, EXE_NOR_OP, 8'hFF};
    logic [31:0] r1s [5] = '{32'h0000_F0F0, 32'hFF00_FF00, 32'hFF00_FF00, 32'h0000_FFFF, 32'hFFFF_FFFF};
    logic [31:0] r2s [5] = '{32'h0F0F_0000, 32'h0FF0_0FF0, 32'h0FF0_0FF0, 32'h00FF_0000, 32'hFFFF_FFFF};
    logic [31:0] exps[5] = '{32'h0F0F_F0F0, 32'h0F00_0F00, 32'hF0F0_F0F0, 32'hFF00_0000, 32'h0000_0000};
    logic [4:0]  wds [5] = '{5'd3, 5'd1, 5'd2, 5'd31, 5'd12};
    for (int i = 0; i < 5; i++) begin
      drive(ops[i], EXE_RES_LOGIC, r1s[i], r2s[i], wds[i], 1'b1);
      tick();
      total += 4;
      if (s1_stall !== 1'b0) begin bad++; $display("FAIL logic%0d_stall got=%b exp=0", i, s1_stall); end
      if (s1_exwreg !== 1'b1) begin bad++; $display("FAIL logic%0d_ex_wreg got=%b exp=1", i, s1_exwreg); end
      if (s1_exwd !== wds[i]) begin bad++; $display("FAIL logic%0d_ex_wd got=%0d exp=%0d", i, s1_exwd, wds[i]); end
      if (s1_exwdata !== exps[i]) begin bad++; $display("FAIL logic%0d_ex_wdata got=%h exp=%h", i, s1_exwdata, exps[i]); end
      nop();
      tick();
      total += 3;
      if (s1_wreg !== 1'b1) begin bad++; $display("FAIL logic%0d_wreg got=%b exp=1", i, s1_wreg); end
      if (s1_wd !== wds[i]) begin bad++; $display("FAIL logic%0d_wd got=%0d exp=%0d", i, s1_wd, wds[i]); end
      if (s1_wdata !== exps[i]) begin bad++; $display("FAIL logic%0d_wdata got=%h exp=%h", i, s1_wdata, exps[i]); end
    end
  endtask
  task automatic test_sra();
    int cyc = 0;
    drive(EXE_SRA_OP, EXE_RES_SHIFT, 32'd5, 32'h8000_0000, 5'd4, 1'b1);
    tick();
    nop();
    while (s1_stall === 1'b1 && cyc < 40) begin
      total++;
      if (s1_exwreg !== 1'b0) begin bad++; $display("FAIL sra_ex_wreg_busy got=%b exp=0", s1_exwreg); end
      cyc++;
      tick();
      total++;
      if (s1_wreg !== 1'b0) begin bad++; $display("FAIL sra_bubble got=%b exp=0", s1_wreg); end
    end
    total += 4;
    if (cyc != 5) begin bad++; $display("FAIL sra_stall_cycles got=%0d exp=5", cyc); end
    if (s1_exwdata !== 32'hFC00_0000) begin bad++; $display("FAIL sra_ex_wdata got=%h exp=fc000000", s1_exwdata); end
    if (s1_exwreg !== 1'b1) begin bad++; $display("FAIL sra_ex_wreg got=%b exp=1", s1_exwreg); end
    if (s1_exwd !== 5'd4) begin bad++; $display("FAIL sra_ex_wd got=%0d exp=4", s1_exwd); end
    tick();
    total += 2;
    if (s1_wdata !== 32'hFC00_0000) begin bad++; $display("FAIL sra_wdata got=%h exp=fc000000", s1_wdata); end
    if (s1_wreg !== 1'b1) begin bad++; $display("FAIL sra_wreg got=%b exp=1", s1_wreg); end
  endtask
  task automatic test_shift_zero();
    drive(EXE_SLL_OP, EXE_RES_SHIFT, 32'h0000_0020, 32'h1234_5678, 5'd6, 1'b1);
    tick();
    total += 5;
    if (s1_stall !== 1'b0) begin bad++; $display("FAIL sll0_stall got=%b exp=0", s1_stall); end
    if (s4_stall !== 1'b0) begin bad++; $display("FAIL sll0_stall4 got=%b exp=0", s4_stall); end
    if (s1_exwdata !== 32'h1234_5678) begin bad++; $display("FAIL sll0_ex_wdata got=%h exp=12345678", s1_exwdata); end
    if (s4_exwdata !== 32'h1234_5678) begin bad++; $display("FAIL sll0_ex_wdata4 got=%h exp=12345678", s4_exwdata); end
    if (s1_exwreg !== 1'b1) begin bad++; $display("FAIL sll0_ex_wreg got=%b exp=1", s1_exwreg); end
    nop();
    tick();
    total++;
    if (s1_wdata !== 32'h1234_5678) begin bad++; $display("FAIL sll0_wdata got=%h exp=12345678", s1_wdata); end
  endtask
  task automatic test_step4();
    int cyc = 0;
    drive(EXE_SRL_OP, EXE_RES_SHIFT, 32'd7, 32'hFFFF_FFFF, 5'd8, 1'b1);
    tick();
    nop();
    while (s4_stall === 1'b1 && cyc < 20) begin cyc++; tick(); end
    total += 3;
    if (cyc != 2) begin bad++; $display("FAIL srl4_stall_cycles got=%0d exp=2", cyc); end
    if (s4_exwdata !== 32'h01FF_FFFF) begin bad++; $display("FAIL srl4_ex_wdata got=%h exp=01ffffff", s4_exwdata); end
    if (s4_exwreg !== 1'b1) begin bad++; $display("FAIL srl4_ex_wreg got=%b exp=1", s4_exwreg); end
    while (s1_stall === 1'b1 && cyc < 40) begin cyc++; tick(); end
    total += 2;
    if (cyc != 7) begin bad++; $display("FAIL srl1_stall_cycles got=%0d exp=7", cyc); end
    if (s1_exwdata !== 32'h01FF_FFFF) begin bad++; $display("FAIL srl1_ex_wdata got=%h exp=01ffffff", s1_exwdata); end
  endtask
  task automatic test_reset_mid();
    drive(EXE_SLL_OP, EXE_RES_SHIFT, 32'd10, 32'h0000_0001, 5'd5, 1'b1);
    tick(); tick(); tick();
    total++;
    if (s1_stall !== 1'b1) begin bad++; $display("FAIL rmid_busy got=%b exp=1", s1_stall); end
    @(negedge clk) rst = 1'b0;
    #1;
    total += 7;
    if (s1_stall !== 1'b0) begin bad++; $display("FAIL rmid_stall got=%b exp=0", s1_stall); end
    if (s4_stall !== 1'b0) begin bad++; $display("FAIL rmid_stall4 got=%b exp=0", s4_stall); end
    if (s1_exwd !== 5'd0) begin bad++; $display("FAIL rmid_ex_wd got=%0d exp=0", s1_exwd); end
    if (s1_exwdata !== 32'd0) begin bad++; $display("FAIL rmid_ex_wdata got=%h exp=0", s1_exwdata); end
    if (s1_exwreg !== 1'b0) begin bad++; $display("FAIL rmid_ex_wreg got=%b exp=0", s1_exwreg); end
    if (s1_wdata !== 32'd0) begin bad++; $display("FAIL rmid_wdata got=%h exp=0", s1_wdata); end
    if (s4_exwd !== 5'd0) begin bad++; $display("FAIL rmid_ex_wd4 got=%0d exp=0", s4_exwd); end
    drive(EXE_XOR_OP, EXE_RES_LOGIC, 32'hA5A5_A5A5, 32'hFFFF_0000, 5'd2, 1'b1);
    rst = 1'b1;
    tick();
    total += 3;
    if (s1_stall !== 1'b0) begin bad++; $display("FAIL rmid_after_stall got=%b exp=0", s1_stall); end
    if (s1_exwdata !== 32'h5A5A_A5A5) begin bad++; $display("FAIL rmid_after_ex_wdata got=%h exp=5a5aa5a5", s1_exwdata); end
    if (s1_exwd !== 5'd2) begin bad++; $display("FAIL rmid_after_ex_wd got=%0d exp=2", s1_exwd); end
    nop();
    tick();
    total++;
    if (s1_wdata !== 32'h5A5A_A5A5) begin bad++; $display("FAIL rmid_after_wdata got=%h exp=5a5aa5a5", s1_wdata); end
  endtask
  task automatic test_stall_i();
    nop();
    tick();
    drive(EXE_AND_OP, EXE_RES_LOGIC, 32'hF0F0_F0F0, 32'h3C3C_3C3C, 5'd7, 1'b1);
    tick();
    drive(EXE_OR_OP, EXE_RES_LOGIC, 32'h1111_1111, 32'h2222_2222, 5'd9, 1'b1);
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total += 5;
      if (s1_exwd !== 5'd7) begin bad++; $display("FAIL stalli%0d_ex_wd got=%0d exp=7", i, s1_exwd); end
      if (s1_exwdata !== 32'h3030_3030) begin bad++; $display("FAIL stalli%0d_ex_wdata got=%h exp=30303030", i, s1_exwdata); end
      if (s1_stall !== 1'b0) begin bad++; $display("FAIL stalli%0d_stall got=%b exp=0", i, s1_stall); end
      if (s1_wdata !== 32'd0) begin bad++; $display("FAIL stalli%0d_wdata got=%h exp=0", i, s1_wdata); end
      if (s1_wreg !== 1'b0) begin bad++; $display("FAIL stalli%0d_wreg got=%b exp=0", i, s1_wreg); end
    end
    nop();
    stall_i = 1'b0;
    tick();
    total += 3;
    if (s1_wdata !== 32'h3030_3030) begin bad++; $display("FAIL stalli_rel_wdata got=%h exp=30303030", s1_wdata); end
    if (s1_wreg !== 1'b1) begin bad++; $display("FAIL stalli_rel_wreg got=%b exp=1", s1_wreg); end
    if (s1_wd !== 5'd7) begin bad++; $display("FAIL stalli_rel_wd got=%0d exp=7", s1_wd); end
  endtask
  task automatic test_shift_under_stall();
    drive(EXE_SLL_OP, EXE_RES_SHIFT, 32'd2, 32'h0000_0003, 5'd10, 1'b1);
    tick();
    nop();
    stall_i = 1'b1;
    tick(); tick();
    total += 2;
    if (s1_stall !== 1'b0) begin bad++; $display("FAIL shstall_done got=%b exp=0", s1_stall); end
    if (s1_exwdata !== 32'h0000_000C) begin bad++; $display("FAIL shstall_ex_wdata got=%h exp=0000000c", s1_exwdata); end
    tick();
    total += 2;
    if (s1_exwd !== 5'd10) begin bad++; $display("FAIL shstall_hold_wd got=%0d exp=10", s1_exwd); end
    if (s1_exwdata !== 32'h0000_000C) begin bad++; $display("FAIL shstall_hold_wdata got=%h exp=0000000c", s1_exwdata); end
    @(negedge clk) stall_i = 1'b0;
    tick();
    total += 2;
    if (s1_wdata !== 32'h0000_000C) begin bad++; $display("FAIL shstall_wdata got=%h exp=0000000c", s1_wdata); end
    if (s1_wreg !== 1'b1) begin bad++; $display("FAIL shstall_wreg got=%b exp=1", s1_wreg); end
  endtask
  initial begin
    test_reset();
    test_logic();
    test_sra();
    test_shift_zero();
    test_step4();
    test_reset_mid();
    test_stall_i();
    test_shift_under_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
